fifo_access_arbiter: RTL and testbench

FIFO_ACCESS_ARBITER -- requirements
Module: fifo_access_arbiter

---
 rtl/fifo_access_arbiter_pkg.sv | 14 +
 rtl/fifo_access_arbiter_if.sv | 28 ++
 rtl/fifo_access_arbiter_rr_pick.sv | 40 ++++
 rtl/fifo_access_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_access_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_access_arbiter_pkg.sv
// rtl/fifo_access_arbiter_pkg.sv - shared state type and default sizing for the FIFO access arbiter
package fifo_ctrl_pkg;

  localparam int DEFAULT_NUM_REQ       = 2;
  localparam int DEFAULT_SETTLE_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    ISSUE  = 2'd2,
    SETTLE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/fifo_access_arbiter_if.sv
// rtl/fifo_access_arbiter_if.sv - requester buttons, FIFO flags and FIFO strobes of the arbiter
interface fifo_access_arbiter_if
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] wr_sel;
  logic               full;
  logic               empty;
  logic               wen;
  logic               ren;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] reject;
  logic               busy;

  modport master (
    output req, wr_sel, full, empty,
    input  wen, ren, grant, reject, busy
  );

  modport slave (
    input  req, wr_sel, full, empty,
    output wen, ren, grant, reject, busy
  );

endinterface

// File: rtl/fifo_access_arbiter_rr_pick.sv
// rtl/fifo_access_arbiter_rr_pick.sv - round-robin pick: first pending index above ptr, wrapping to 0
module rr_pick
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic             hi_valid;
  logic             lo_valid;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Indices above ptr outrank the wrapped-around ones at or below it.
  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pending[i] && (i > int'(ptr)) && !hi_valid) begin
        hi_valid = 1'b1;
        hi_idx   = IDX_W'(i);
      end
      if (pending[i] && (i <= int'(ptr)) && !lo_valid) begin
        lo_valid = 1'b1;
        lo_idx   = IDX_W'(i);
      end
    end
  end

  assign valid  = hi_valid | lo_valid;
  assign winner = hi_valid ? hi_idx : lo_idx;

endmodule

// File: rtl/fifo_access_arbiter.sv
// rtl/fifo_access_arbiter.sv - serialises button-driven FIFO read/write requests into single wen/ren pulses
module fifo_access_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ       = DEFAULT_NUM_REQ,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset_n,
  fifo_access_arbiter_if.slave bus
);

  localparam int                 IDX_W     = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]   PTR_RESET = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);
  localparam logic [4:0]         SETTLE_N  = 5'(SETTLE_CYCLES);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] req_q, req_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] op_q, op_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               wen_q, wen_d;
  logic               ren_q, ren_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] reject_q, reject_d;

  logic [IDX_W-1:0]   pick_w;
  logic               pick_valid;
  logic               issue_en;
  logic               sel_wr;
  logic               access_ok;
  logic [NUM_REQ-1:0] win_mask;
  logic [NUM_REQ-1:0] rise;
  logic [NUM_REQ-1:0] accept;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .pending (pending_q),
    .ptr     (ptr_q),
    .winner  (pick_w),
    .valid   (pick_valid)
  );

  assign issue_en  = (state_q == ARB) && pick_valid;
  assign win_mask  = issue_en ? (ONE << pick_w) : '0;
  assign sel_wr    = op_q[pick_w];
  assign access_ok = sel_wr ? ~bus.full : ~bus.empty;
  assign rise      = bus.req & ~req_q;
  // A fresh press on the requester being served re-arms it rather than being lost.
  assign accept    = rise & (~pending_q | win_mask);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      req_q     <= '1;
      pending_q <= '0;
      op_q      <= '0;
      ptr_q     <= PTR_RESET;
      cnt_q     <= '0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      grant_q   <= '0;
      reject_q  <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      pending_q <= pending_d;
      op_q      <= op_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      grant_q   <= grant_d;
      reject_q  <= reject_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = bus.req;
    pending_d = (pending_q & ~win_mask) | accept;
    op_d      = (op_q & ~accept) | (bus.wr_sel & accept);
    ptr_d     = issue_en ? pick_w : ptr_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) state_d = ARB;
      end
      ARB: begin
        state_d = pick_valid ? ISSUE : IDLE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = (SETTLE_CYCLES > 0) ? SETTLE : IDLE;
      end
      SETTLE: begin
        if (({1'b0, cnt_q} + 5'd1) == SETTLE_N) state_d = IDLE;
        else                                    cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decided from the flags seen in ARB and registered into the ISSUE cycle.
  always_comb begin
    wen_d    = issue_en & sel_wr & ~bus.full;
    ren_d    = issue_en & ~sel_wr & ~bus.empty;
    grant_d  = access_ok ? win_mask : '0;
    reject_d = access_ok ? '0 : win_mask;
  end

  assign bus.wen    = wen_q;
  assign bus.ren    = ren_q;
  assign bus.grant  = grant_q;
  assign bus.reject = reject_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb/tb_fifo_access_arbiter.sv - directed bench for fifo_access_arbiter with a cycle-level reference model
module tb_fifo_access_arbiter;

  localparam int N = 2;
  localparam int S = 1;
  localparam logic [N-1:0] ONE = N'(1);

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  fifo_access_arbiter_if #(.NUM_REQ(N)) bus ();

  fifo_access_arbiter #(
    .NUM_REQ       (N),
    .SETTLE_CYCLES (S)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks     = 0;
  int fails      = 0;
  int wen_pulses = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: age counts cycles since an access began (0 = nothing in flight).
  logic [N-1:0] m_req_q, m_pend, m_op, e_grant, e_reject;
  logic         e_wen, e_ren;
  int           m_ptr, age;

  always @(posedge clock or negedge reset_n) begin
    logic [N-1:0] pend, op, rise, g, r;
    logic         w_en, r_en, found;
    int           a, p, w, idx;
    if (!reset_n) begin
      m_req_q  <= '1;
      m_pend   <= '0;
      m_op     <= '0;
      m_ptr    <= N - 1;
      age      <= 0;
      e_wen    <= 1'b0;
      e_ren    <= 1'b0;
      e_grant  <= '0;
      e_reject <= '0;
    end else begin
      pend = m_pend; op = m_op; a = age; p = m_ptr;
      rise = bus.req & ~m_req_q;
      g = '0; r = '0; w_en = 1'b0; r_en = 1'b0;
      if (a == 0) begin
        if (pend != '0) a = 1;
      end else if (a == 1) begin
        found = 1'b0; w = 0;
        for (int k = 1; k <= N; k++) begin
          idx = (p + k) % N;
          if (!found && ((pend >> idx) & ONE) != '0) begin
            found = 1'b1;
            w = idx;
          end
        end
        if (((op >> w) & ONE) != '0) begin
          if (!bus.full) begin w_en = 1'b1; g = ONE << w; end
          else r = ONE << w;
        end else begin
          if (!bus.empty) begin r_en = 1'b1; g = ONE << w; end
          else r = ONE << w;
        end
        pend = pend & ~(ONE << w);
        p = w;
        a = 2;
      end else if (a == 2) begin
        a = (S > 0) ? 3 : 0;
      end else if (a >= 2 + S) begin
        a = 0;
      end else begin
        a = a + 1;
      end
      for (int i = 0; i < N; i++) begin
        if (rise[i] && !pend[i]) begin
          pend[i] = 1'b1;
          op[i]   = bus.wr_sel[i];
        end
      end
      m_req_q  <= bus.req;
      m_pend   <= pend;
      m_op     <= op;
      m_ptr    <= p;
      age      <= a;
      e_wen    <= w_en;
      e_ren    <= r_en;
      e_grant  <= g;
      e_reject <= r;
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      check("wen",    int'(bus.wen),    int'(e_wen));
      check("ren",    int'(bus.ren),    int'(e_ren));
      check("grant",  int'(bus.grant),  int'(e_grant));
      check("reject", int'(bus.reject), int'(e_reject));
      check("busy",   int'(bus.busy),   (age != 0) ? 1 : 0);
      check("wen_ren_excl", int'(bus.wen & bus.ren), 0);
      check("grant_reject_onehot0", int'($onehot0(bus.grant | bus.reject)), 1);
      if (bus.wen) wen_pulses++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input int i, input bit wr);
    bus.wr_sel = wr ? (bus.wr_sel | (ONE << i)) : (bus.wr_sel & ~(ONE << i));
    bus.req    = bus.req | (ONE << i);
  endtask

  task automatic release_req(input int i);
    bus.req = bus.req & ~(ONE << i);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] wr;
    logic         full;
    logic         empty;
    int           hold;
  } vec_t;

  vec_t vecs[10] = '{
    '{2'b11, 2'b11, 1'b0, 1'b0, 3},
    '{2'b00, 2'b11, 1'b0, 1'b0, 2},
    '{2'b11, 2'b10, 1'b0, 1'b1, 4},
    '{2'b01, 2'b10, 1'b1, 1'b1, 2},
    '{2'b10, 2'b00, 1'b0, 1'b0, 5},
    '{2'b00, 2'b00, 1'b0, 1'b0, 6},
    '{2'b11, 2'b00, 1'b0, 1'b0, 3},
    '{2'b00, 2'b01, 1'b1, 1'b0, 8},
    '{2'b11, 2'b01, 1'b1, 1'b0, 2},
    '{2'b00, 2'b00, 1'b0, 1'b0, 10}
  };

  int base;

  initial begin
    bus.req = '0; bus.wr_sel = '0; bus.full = 1'b0; bus.empty = 1'b0;
    cyc(2);
    check("rst_wen",    int'(bus.wen),    0);
    check("rst_ren",    int'(bus.ren),    0);
    check("rst_grant",  int'(bus.grant),  0);
    check("rst_reject", int'(bus.reject), 0);
    check("rst_busy",   int'(bus.busy),   0);
    reset_n = 1'b1;
    cyc(3);

    // single write, latency and one-cycle pulse
    press(0, 1'b1);
    cyc(3);
    check("t1_wen", int'(bus.wen), 1);
    check("t1_grant", int'(bus.grant), 1);
    check("t1_ren", int'(bus.ren), 0);
    cyc(1);
    check("t1_wen_drop", int'(bus.wen), 0);
    release_req(0);
    cyc(5);

    // read while empty is rejected
    bus.empty = 1'b1;
    press(1, 1'b0);
    cyc(3);
    check("t2_reject", int'(bus.reject), 2);
    check("t2_ren", int'(bus.ren), 0);
    check("t2_wen", int'(bus.wen), 0);
    release_req(1);
    cyc(5);
    bus.empty = 1'b0;

    // simultaneous presses with ptr=1: requester 0 first, 4 cycles apart
    press(0, 1'b1); press(1, 1'b0);
    cyc(3);
    check("t3_wen", int'(bus.wen), 1);
    check("t3_grant0", int'(bus.grant), 1);
    cyc(4);
    check("t3_ren", int'(bus.ren), 1);
    check("t3_grant1", int'(bus.grant), 2);
    bus.req = '0;
    cyc(6);

    // move ptr to 0, then simultaneous presses serve requester 1 first
    press(0, 1'b1);
    cyc(3);
    release_req(0);
    cyc(5);
    press(0, 1'b1); press(1, 1'b0);
    cyc(3);
    check("t3b_ren", int'(bus.ren), 1);
    check("t3b_grant1", int'(bus.grant), 2);
    cyc(4);
    check("t3b_wen", int'(bus.wen), 1);
    check("t3b_grant0", int'(bus.grant), 1);
    bus.req = '0;
    cyc(6);

    // held button gives one pulse, re-press gives another
    base = wen_pulses;
    press(0, 1'b1);
    cyc(20);
    check("t4_held_pulses", wen_pulses - base, 1);
    release_req(0);
    cyc(2);
    press(0, 1'b1);
    cyc(6);
    check("t4_repress_pulses", wen_pulses - base, 2);
    release_req(0);
    cyc(4);

    // full rising just after the ARB sample does not cancel the write
    press(0, 1'b1);
    repeat (3) @(posedge clock);
    #1 bus.full = 1'b1;
    @(negedge clock);
    check("t5_wen_late_full", int'(bus.wen), 1);
    check("t5_grant_late_full", int'(bus.grant), 1);
    release_req(0);
    cyc(5);
    press(0, 1'b1);
    cyc(3);
    check("t5_reject_full", int'(bus.reject), 1);
    check("t5_wen_full", int'(bus.wen), 0);
    release_req(0);
    bus.full = 1'b0;
    cyc(5);

    // reset during ISSUE truncates the pulse; held button ignored afterwards
    base = wen_pulses;
    press(0, 1'b1);
    repeat (3) @(posedge clock);
    #1 check("t6_wen_before_rst", int'(bus.wen), 1);
    #1 reset_n = 1'b0;
    #1;
    check("t6_wen_rst", int'(bus.wen), 0);
    check("t6_grant_rst", int'(bus.grant), 0);
    check("t6_busy_rst", int'(bus.busy), 0);
    @(negedge clock);
    cyc(2);
    reset_n = 1'b1;
    cyc(10);
    check("t6_held_after_rst", wen_pulses - base, 0);
    check("t6_idle_after_rst", int'(bus.busy), 0);
    release_req(0);
    cyc(2);
    press(0, 1'b1);
    cyc(6);
    check("t6_repress", wen_pulses - base, 1);
    release_req(0);
    cyc(5);

    // mixed vector table, checked by the model every cycle
    foreach (vecs[v]) begin
      bus.req    = vecs[v].req;
      bus.wr_sel = vecs[v].wr;
      bus.full   = vecs[v].full;
      bus.empty  = vecs[v].empty;
      cyc(vecs[v].hold);
    end
    cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
